// File: rtl/serial_pkg.sv
// Shared definitions for the serial FIFO controller: TX sequencer state
// encoding, STATUS/CTRL bit positions and the DATA/STATUS register select.
package serial_pkg;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_HOLD  = 2'd2
    } tx_state_t;

    // STATUS read word layout
    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_OVERRUN      = 2;
    localparam int ST_RX_IE        = 3;
    localparam int ST_TX_IE        = 4;
    localparam int ST_RX_CNT_LSB   = 8;
    localparam int ST_TX_CNT_LSB   = 16;

    // CTRL write word layout
    localparam int CTRL_RX_IE   = 0;
    localparam int CTRL_TX_IE   = 1;
    localparam int CTRL_OVR_CLR = 2;

    // Register select on mode_i
    localparam logic MODE_DATA   = 1'b0;
    localparam logic MODE_STATUS = 1'b1;

endpackage

// File: rtl/serial_fifo_ctrl_if.sv
// Bus and serial-side signals of serial_fifo_ctrl.
//   CPU side : enable_i, readEnable_i, mode_i, dataSave_i -> dataLoad_o, int_o
//   RX side  : rxdReady_i, rxdData_i
//   TX side  : txdBusy_i -> txdStart_o, txdData_o
// slave  = the controller, master = the CPU/serial environment.
interface serial_fifo_ctrl_if;
    logic        enable_i;
    logic        readEnable_i;
    logic        mode_i;
    logic [31:0] dataSave_i;
    logic [31:0] dataLoad_o;
    logic        int_o;
    logic        rxdReady_i;
    logic [7:0]  rxdData_i;
    logic        txdBusy_i;
    logic        txdStart_o;
    logic [7:0]  txdData_o;

    modport slave (
        input  enable_i, readEnable_i, mode_i, dataSave_i,
        input  rxdReady_i, rxdData_i, txdBusy_i,
        output dataLoad_o, int_o, txdStart_o, txdData_o
    );

    modport master (
        output enable_i, readEnable_i, mode_i, dataSave_i,
        output rxdReady_i, rxdData_i, txdBusy_i,
        input  dataLoad_o, int_o, txdStart_o, txdData_o
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head data.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push/wdata     : write request and data (accepted when not full, or when
//                    a pop happens in the same cycle)
//   pop/rdata      : read request (ignored when empty) and current head
//   full/empty     : occupancy flags
//   count          : entries held, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/serial_fifo_ctrl.sv
// CPU-facing serial controller: RX/TX byte FIFOs, STATUS/CTRL register,
// TX start sequencer and a registered interrupt.
//   clk, rst_n : 25 MHz clock, asynchronous active-low reset
//   bus        : serial_fifo_ctrl_if.slave (CPU access, RX byte input,
//                TX start/data output, interrupt)
// Optional feature: define SERIAL_OVERRUN_FLAG_EN to build the RX overrun
// flag (STATUS bit2, CTRL bit2 clear, overrun interrupt term).
module serial_fifo_ctrl
    import serial_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_fifo_ctrl_if.slave  bus
);
    localparam int RXCW = $clog2(RX_DEPTH) + 1;
    localparam int TXCW = $clog2(TX_DEPTH) + 1;

    logic            data_rd, data_wr, stat_rd, ctrl_wr;
    logic [7:0]      rx_head, tx_head;
    logic            rx_full, rx_empty, tx_full, tx_empty;
    logic [RXCW-1:0] rx_count;
    logic [TXCW-1:0] tx_count;
    logic            rx_ie, tx_ie, overrun;
    logic            tx_pop;
    logic [7:0]      txd_data;
    logic [31:0]     status;
    tx_state_t       state, state_nx;

    assign data_rd = bus.enable_i &  bus.readEnable_i & (bus.mode_i == MODE_DATA);
    assign data_wr = bus.enable_i & ~bus.readEnable_i & (bus.mode_i == MODE_DATA);
    assign stat_rd = bus.enable_i &  bus.readEnable_i & (bus.mode_i == MODE_STATUS);
    assign ctrl_wr = bus.enable_i & ~bus.readEnable_i & (bus.mode_i == MODE_STATUS);

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.rxdReady_i),
        .pop   (data_rd),
        .wdata (bus.rxdData_i),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_wr),
        .pop   (tx_pop),
        .wdata (bus.dataSave_i[7:0]),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ie <= 1'b0;
            tx_ie <= 1'b0;
        end else if (ctrl_wr) begin
            rx_ie <= bus.dataSave_i[CTRL_RX_IE];
            tx_ie <= bus.dataSave_i[CTRL_TX_IE];
        end
    end

`ifdef SERIAL_OVERRUN_FLAG_EN
    // A full RX FIFO is never empty, so a DATA read here always frees a slot.
    logic ovr_set;
    assign ovr_set = bus.rxdReady_i & rx_full & ~data_rd;

    // A new overrun wins over a clear issued in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (ovr_set)
            overrun <= 1'b1;
        else if (ctrl_wr && bus.dataSave_i[CTRL_OVR_CLR])
            overrun <= 1'b0;
    end
`else
    assign overrun = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= T_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_pop   = 1'b0;
        case (state)
            T_IDLE:  if (!tx_empty && !bus.txdBusy_i) state_nx = T_START;
            T_START: begin
                tx_pop   = 1'b1;
                state_nx = T_HOLD;
            end
            // Gives the transmitter a cycle to raise busy before re-arming.
            T_HOLD:  state_nx = T_IDLE;
            default: state_nx = T_IDLE;
        endcase
    end

    // Head is captured on entry to T_START and held until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            txd_data <= 8'h00;
        else if (state == T_IDLE && state_nx == T_START)
            txd_data <= tx_head;
    end

    assign bus.txdStart_o = (state == T_START);
    assign bus.txdData_o  = txd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.int_o <= 1'b0;
        else
            bus.int_o <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty) | (overrun & rx_ie);
    end

    always_comb begin
        status                          = '0;
        status[ST_TX_NOT_FULL]          = ~tx_full;
        status[ST_RX_NOT_EMPTY]         = ~rx_empty;
        status[ST_OVERRUN]              = overrun;
        status[ST_RX_IE]                = rx_ie;
        status[ST_TX_IE]                = tx_ie;
        status[ST_RX_CNT_LSB +: 8]      = 8'(rx_count);
        status[ST_TX_CNT_LSB +: 8]      = 8'(tx_count);
    end

    always_comb begin
        bus.dataLoad_o = 32'h0;
        if (data_rd && !rx_empty)
            bus.dataLoad_o = {24'h0, rx_head};
        else if (stat_rd)
            bus.dataLoad_o = status;
    end

endmodule

// File: doc/serial_fifo_ctrl.md
SERIAL_FIFO_CTRL -- requirements
Module: serial_fifo_ctrl

Interface
REQ-001 Parameter RX_DEPTH, default 16: RX FIFO entries; power of two, at least 2.
REQ-002 Parameter TX_DEPTH, default 16: TX FIFO entries; power of two, at least 2.
REQ-003 clk  in  1  system clock (25 MHz domain); all logic on posedge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 enable_i  in  1  bus access strobe, one cycle per access.
REQ-006 readEnable_i  in  1  1 = read, 0 = write.
REQ-007 mode_i  in  1  register select: 0 = DATA, 1 = STATUS/CTRL.
REQ-008 dataSave_i  in  32  write data.
REQ-009 dataLoad_o  out  32  read data, combinational from current state.
REQ-010 int_o  out  1  registered interrupt request.
REQ-011 rxdReady_i  in  1  one-cycle pulse: receiver byte valid.
REQ-012 rxdData_i  in  8  received byte.
REQ-013 txdBusy_i  in  1  transmitter busy.
REQ-014 txdStart_o  out  1  one-cycle transmit start.
REQ-015 txdData_o  out  8  byte to transmit, valid while txdStart_o is 1.

Function
REQ-016 DATA read (enable_i & readEnable_i & !mode_i): dataLoad_o = {24'h0, RX head}; pop at the same posedge. If RX is empty: dataLoad_o = 0 and no pop.
REQ-017 DATA write: push dataSave_i[7:0] into TX at the posedge. If TX is full, the byte is dropped silently.
REQ-018 STATUS read: bit0 = TX not full; bit1 = RX not empty; bit2 = overrun; bit3 = rxIe; bit4 = txIe; [15:8] = RX count; [23:16] = TX count; all other bits 0.
REQ-019 CTRL write: dataSave_i[0] -> rxIe; dataSave_i[1] -> txIe; dataSave_i[2] = 1 clears overrun.
REQ-020 RX push happens on rxdReady_i. If RX is full with no pop in the same cycle, the byte is discarded and overrun is set.
REQ-021 Simultaneous push and pop on either FIFO: both take effect and the count is unchanged. On a full RX FIFO the push is accepted.
REQ-022 FIFO pointers wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits, zero-extended into the STATUS fields.
REQ-023 TX FSM states and transitions:
  - T_IDLE -> T_START when TX not empty and !txdBusy_i.
  - T_START: txdStart_o = 1, txdData_o = TX head, pop TX; -> T_HOLD.
  - T_HOLD: one cycle so txdBusy_i can rise; -> T_IDLE.
REQ-024 Outside T_START, txdStart_o = 0 and txdData_o holds its last value.
REQ-025 int_o is registered one cycle after (rxIe & RX not empty) | (txIe & TX empty).
REQ-026 A CPU TX push in the same cycle as the FSM pop follows REQ-021.

Reset
REQ-027 While rst_n = 0, the following hold immediately:
  - FIFOs empty and pointers 0.
  - FSM in T_IDLE.
  - txdStart_o = 0, txdData_o = 0, int_o = 0.
  - rxIe = 0, txIe = 0, overrun = 0.
REQ-028 Reset mid-transmit abandons the FSM state and the queued bytes. Output returns to T_IDLE values with no further txdStart_o pulse.

Configuration
REQ-029 Macro SERIAL_OVERRUN_FLAG_EN defined: the overrun flag, STATUS bit2, and the CTRL bit2 clear are implemented. An interrupt is also raised when overrun & rxIe.
REQ-030 SERIAL_OVERRUN_FLAG_EN undefined: no overrun register; STATUS bit2 reads 0; CTRL bit2 is ignored. RX drop on full still applies.

Structure
REQ-031 Package serial_pkg holds:
  - TX FSM state encoding.
  - STATUS/CTRL bit-position constants.
  - DATA/STATUS mode constants.
REQ-032 Sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count) is instantiated once for RX and once for TX.

Verification
REQ-033 Reset, then 3 rxdReady_i pulses with 0x41, 0x42, 0x43 -> STATUS [15:8] = 3, bit1 = 1. Three DATA reads return 0x41, 0x42, 0x43; a fourth read returns 0.
REQ-034 Write 0x55, 0xAA to DATA with txdBusy_i low -> txdStart_o pulses carrying 0x55 then 0xAA, each pulse issued only after txdBusy_i falls.
REQ-035 With RX_DEPTH = 4, send 5 bytes with no reads -> count = 4, bytes 1-4 retained, overrun = 1 (macro defined). CTRL write 0x4 clears overrun.
REQ-036 RX full with a DATA read and rxdReady_i in the same cycle -> count stays 4, no overrun, new byte at tail.
REQ-037 CTRL write 0x1, then one RX byte -> int_o = 1 one cycle after the push. A DATA read empties RX -> int_o = 0 one cycle later.
REQ-038 Assert rst_n = 0 during T_HOLD with 5 bytes queued -> txdStart_o stays 0, TX count = 0 after release.
